// File: rtl/alu_seq_pkg.sv
// Shared opcode, flag-index and FSM-state definitions for the ALU command sequencer.
package alu_seq_pkg;

  localparam logic [3:0] OP_ADD = 4'd1;
  localparam logic [3:0] OP_ADC = 4'd2;
  localparam logic [3:0] OP_SUB = 4'd3;
  localparam logic [3:0] OP_INC = 4'd4;
  localparam logic [3:0] OP_DEC = 4'd5;
  localparam logic [3:0] OP_AND = 4'd6;
  localparam logic [3:0] OP_NOT = 4'd7;
  localparam logic [3:0] OP_ROL = 4'd8;
  localparam logic [3:0] OP_ROR = 4'd9;
  localparam logic [3:0] OP_MAX = 4'd9;

  localparam int FLG_C = 3;
  localparam int FLG_B = 2;
  localparam int FLG_Z = 1;
  localparam int FLG_P = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WAIT = 2'd2
  } seq_state_t;

  function automatic logic op_is_valid(input logic [3:0] op);
    return (op >= OP_ADD) && (op <= OP_MAX);
  endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// Command FIFO holding {op, b, a}; extra pointer MSB distinguishes full from empty.
module alu_cmd_fifo
  import alu_seq_pkg::*;
#(
  parameter int W     = 20,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         do_push;
  logic         do_pop;

  // A push into a full FIFO is refused even when a pop happens in the same cycle.
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty   = (wr_ptr == rd_ptr);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Issues buffered ALU commands one at a time and captures results with a valid/ready handshake.
// Optional ALU_SEQ_STATS_EN adds saturating stat_issued/stat_errors counters.
module alu_cmd_sequencer
  import alu_seq_pkg::*;
#(
  parameter int BUS   = 8,
  parameter int DEPTH = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           cmd_valid,
  output logic           cmd_ready,
  input  logic [BUS-1:0] cmd_a,
  input  logic [BUS-1:0] cmd_b,
  input  logic [3:0]     cmd_op,
  output logic [BUS-1:0] alu_a,
  output logic [BUS-1:0] alu_b,
  output logic           alu_carry_in,
  output logic [3:0]     alu_op_code,
  input  logic [BUS-1:0] alu_y,
  input  logic           alu_carry_out,
  input  logic           alu_borrow,
  input  logic           alu_zero,
  input  logic           alu_parity,
  input  logic           alu_invalid_op,
  output logic           res_valid,
  input  logic           res_ready,
  output logic [BUS-1:0] res_y,
  output logic [3:0]     res_flags,
  output logic           res_err,
  output logic           cf
`ifdef ALU_SEQ_STATS_EN
  ,
  output logic [15:0]    stat_issued,
  output logic [15:0]    stat_errors
`endif
);

  localparam int CW = 4 + 2 * BUS;

  seq_state_t    state;
  seq_state_t    next_state;
  logic [CW-1:0] fifo_din;
  logic [CW-1:0] fifo_dout;
  logic          fifo_full;
  logic          fifo_empty;
  logic          fifo_pop;
  logic          exec_err;
  logic [3:0]    alu_flags;

  assign fifo_din  = {cmd_op, cmd_b, cmd_a};
  assign cmd_ready = !fifo_full;

  alu_cmd_fifo #(
    .W     (CW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (cmd_valid),
    .din   (fifo_din),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    fifo_pop   = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop   = 1'b1;
          next_state = EXEC;
        end
      end
      EXEC: next_state = WAIT;
      WAIT: begin
        if (res_ready) begin
          if (!fifo_empty) begin
            fifo_pop   = 1'b1;
            next_state = EXEC;
          end else begin
            next_state = IDLE;
          end
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    alu_flags        = '0;
    alu_flags[FLG_C] = alu_carry_out;
    alu_flags[FLG_B] = alu_borrow;
    alu_flags[FLG_Z] = alu_zero;
    alu_flags[FLG_P] = alu_parity;
  end

  assign alu_carry_in = (alu_op_code == OP_ADC) && cf;
  assign exec_err     = alu_invalid_op || !op_is_valid(alu_op_code);

  // Operand registers load on every pop; the result register captures in EXEC and drops on retire.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      alu_a       <= '0;
      alu_b       <= '0;
      alu_op_code <= '0;
      res_valid   <= 1'b0;
      res_y       <= '0;
      res_flags   <= '0;
      res_err     <= 1'b0;
      cf          <= 1'b0;
    end else begin
      if (fifo_pop) begin
        alu_a       <= fifo_dout[BUS-1:0];
        alu_b       <= fifo_dout[2*BUS-1:BUS];
        alu_op_code <= fifo_dout[CW-1 -: 4];
      end
      if (state == EXEC) begin
        res_valid <= 1'b1;
        res_err   <= exec_err;
        res_y     <= exec_err ? '0 : alu_y;
        res_flags <= exec_err ? 4'd0 : alu_flags;
        if (!exec_err) begin
          if (alu_op_code == OP_ADD || alu_op_code == OP_ADC) cf <= alu_carry_out;
          else if (alu_op_code == OP_SUB)                     cf <= alu_borrow;
        end
      end else if (state == WAIT && res_ready) begin
        res_valid <= 1'b0;
      end
    end
  end

`ifdef ALU_SEQ_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_issued <= '0;
      stat_errors <= '0;
    end else if (state == EXEC) begin
      if (stat_issued != 16'hFFFF)             stat_issued <= stat_issued + 16'd1;
      if (exec_err && stat_errors != 16'hFFFF) stat_errors <= stat_errors + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer with a behavioural ALU closing the loop.
module tb_alu_cmd_sequencer;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] cmd_a, cmd_b;
  logic [3:0] cmd_op;
  logic [7:0] alu_a, alu_b, alu_y;
  logic       alu_carry_in;
  logic [3:0] alu_op_code;
  logic       alu_carry_out, alu_borrow, alu_zero, alu_parity, alu_invalid_op;
  logic       res_valid, res_ready, res_err, cf;
  logic [7:0] res_y;
  logic [3:0] res_flags;
`ifdef ALU_SEQ_STATS_EN
  logic [15:0] stat_issued, stat_errors;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_cmd_sequencer #(.BUS(8), .DEPTH(4)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_a          (cmd_a),
    .cmd_b          (cmd_b),
    .cmd_op         (cmd_op),
    .alu_a          (alu_a),
    .alu_b          (alu_b),
    .alu_carry_in   (alu_carry_in),
    .alu_op_code    (alu_op_code),
    .alu_y          (alu_y),
    .alu_carry_out  (alu_carry_out),
    .alu_borrow     (alu_borrow),
    .alu_zero       (alu_zero),
    .alu_parity     (alu_parity),
    .alu_invalid_op (alu_invalid_op),
    .res_valid      (res_valid),
    .res_ready      (res_ready),
    .res_y          (res_y),
    .res_flags      (res_flags),
    .res_err        (res_err),
    .cf             (cf)
`ifdef ALU_SEQ_STATS_EN
    ,
    .stat_issued    (stat_issued),
    .stat_errors    (stat_errors)
`endif
  );

  // Behavioural ALU: invalid opcodes return deliberate garbage the sequencer must suppress.
  always_comb begin
    logic [8:0] sum;
    sum            = '0;
    alu_y          = '0;
    alu_carry_out  = 1'b0;
    alu_borrow     = 1'b0;
    alu_invalid_op = 1'b0;
    case (alu_op_code)
      4'd1: begin sum = {1'b0, alu_a} + {1'b0, alu_b}; alu_y = sum[7:0]; alu_carry_out = sum[8]; end
      4'd2: begin sum = {1'b0, alu_a} + {1'b0, alu_b} + {8'd0, alu_carry_in}; alu_y = sum[7:0]; alu_carry_out = sum[8]; end
      4'd3: begin alu_y = alu_a - alu_b; alu_borrow = (alu_a < alu_b); end
      4'd4: begin sum = {1'b0, alu_a} + 9'd1; alu_y = sum[7:0]; alu_carry_out = sum[8]; end
      4'd5: begin alu_y = alu_a - 8'd1; alu_borrow = (alu_a == 8'd0); end
      4'd6: alu_y = alu_a & alu_b;
      4'd7: alu_y = ~alu_a;
      4'd8: begin alu_y = {alu_a[6:0], alu_a[7]}; alu_carry_out = alu_a[7]; end
      4'd9: begin alu_y = {alu_a[0], alu_a[7:1]}; alu_carry_out = alu_a[0]; end
      default: begin alu_y = 8'hA5; alu_carry_out = 1'b1; alu_invalid_op = 1'b1; end
    endcase
    alu_zero   = (alu_y == 8'd0);
    alu_parity = ^alu_y;
  end

  typedef struct {
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] y;
    logic [3:0] flags;
    logic       err;
    logic       cf;
  } vec_t;

  vec_t vecs[16];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called at a negedge; offers one command for exactly one rising edge.
  task automatic applyStimulus(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                               output logic accepted);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_a     = a;
    cmd_b     = b;
    accepted  = cmd_ready;
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic       acc;
    logic       cf_model;
    logic       cin_exp;
    int         n_acc;
    int         got;
    int         last_cyc;
    logic [7:0] seen_y[5];
    int         seen_cyc[5];
    logic       saw_valid;

    vecs[0]  = '{4'd1,  8'd55,  8'd67,  8'd122, 4'b0001, 1'b0, 1'b0};
    vecs[1]  = '{4'd1,  8'd200, 8'd100, 8'd44,  4'b1001, 1'b0, 1'b1};
    vecs[2]  = '{4'd2,  8'd1,   8'd1,   8'd3,   4'b0000, 1'b0, 1'b0};
    vecs[3]  = '{4'd3,  8'd10,  8'd10,  8'd0,   4'b0010, 1'b0, 1'b0};
    vecs[4]  = '{4'd3,  8'd100, 8'd10,  8'd90,  4'b0000, 1'b0, 1'b0};
    vecs[5]  = '{4'd3,  8'd5,   8'd7,   8'hFE,  4'b0101, 1'b0, 1'b1};
    vecs[6]  = '{4'd4,  8'hFF,  8'd0,   8'h00,  4'b1010, 1'b0, 1'b1};
    vecs[7]  = '{4'd10, 8'd3,   8'd4,   8'h00,  4'b0000, 1'b1, 1'b1};
    vecs[8]  = '{4'd2,  8'h0F,  8'h10,  8'h20,  4'b0001, 1'b0, 1'b0};
    vecs[9]  = '{4'd6,  8'hF0,  8'h3C,  8'h30,  4'b0000, 1'b0, 1'b0};
    vecs[10] = '{4'd7,  8'h0F,  8'h00,  8'hF0,  4'b0000, 1'b0, 1'b0};
    vecs[11] = '{4'd8,  8'h81,  8'h00,  8'h03,  4'b1000, 1'b0, 1'b0};
    vecs[12] = '{4'd9,  8'h01,  8'h00,  8'h80,  4'b1001, 1'b0, 1'b0};
    vecs[13] = '{4'd5,  8'h00,  8'h00,  8'hFF,  4'b0100, 1'b0, 1'b0};
    vecs[14] = '{4'd0,  8'h12,  8'h34,  8'h00,  4'b0000, 1'b1, 1'b0};
    vecs[15] = '{4'd15, 8'h01,  8'h01,  8'h00,  4'b0000, 1'b1, 1'b0};

    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_a     = '0;
    cmd_b     = '0;
    cmd_op    = '0;
    res_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    checkOutput("reset_cmd_ready", cmd_ready, 1);
    checkOutput("reset_res_valid", res_valid, 0);
    checkOutput("reset_res_y",     res_y, 0);
    checkOutput("reset_res_flags", res_flags, 0);
    checkOutput("reset_cf",        cf, 0);
    checkOutput("reset_alu_op",    alu_op_code, 0);

    cf_model = 1'b0;
    for (int i = 0; i < 16; i++) begin
      cin_exp = (vecs[i].op == 4'd2) ? cf_model : 1'b0;
      applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, acc);
      cmd_valid = 1'b0;
      checkOutput($sformatf("v%0d_accept", i), acc, 1);
      checkOutput($sformatf("v%0d_valid_n1", i), res_valid, 0);
      @(negedge clk);
      checkOutput($sformatf("v%0d_alu_op", i), alu_op_code, vecs[i].op);
      checkOutput($sformatf("v%0d_alu_a", i), alu_a, vecs[i].a);
      checkOutput($sformatf("v%0d_alu_cin", i), alu_carry_in, cin_exp);
      checkOutput($sformatf("v%0d_valid_n2", i), res_valid, 0);
      @(negedge clk);
      checkOutput($sformatf("v%0d_valid", i), res_valid, 1);
      checkOutput($sformatf("v%0d_y", i), res_y, vecs[i].y);
      checkOutput($sformatf("v%0d_flags", i), res_flags, vecs[i].flags);
      checkOutput($sformatf("v%0d_err", i), res_err, vecs[i].err);
      checkOutput($sformatf("v%0d_cf", i), cf, vecs[i].cf);
      cf_model = vecs[i].cf;
      @(negedge clk);
      checkOutput($sformatf("v%0d_retired", i), res_valid, 0);
    end

`ifdef ALU_SEQ_STATS_EN
    checkOutput("stat_issued", stat_issued, 16);
    checkOutput("stat_errors", stat_errors, 3);
`endif

    // Backpressure: one result held plus four queued; the last two offers are refused.
    res_ready = 1'b0;
    n_acc = 0;
    for (int k = 1; k <= 7; k++) begin
      applyStimulus(4'd1, 8'(10 * k), 8'd1, acc);
      checkOutput($sformatf("bp_accept%0d", k), acc, (k <= 5) ? 1 : 0);
      if (acc) n_acc++;
    end
    cmd_valid = 1'b0;
    checkOutput("bp_accepted", n_acc, 5);
    repeat (3) begin
      checkOutput("bp_cmd_ready_low", cmd_ready, 0);
      checkOutput("bp_hold_valid", res_valid, 1);
      checkOutput("bp_hold_y", res_y, 8'd11);
      @(negedge clk);
    end

    res_ready = 1'b1;
    got = 0;
    for (int c = 0; c < 30 && got < 5; c++) begin
      if (res_valid) begin
        seen_y[got]   = res_y;
        seen_cyc[got] = c;
        got++;
      end
      @(negedge clk);
    end
    checkOutput("bp_drain_count", got, 5);
    last_cyc = 0;
    for (int k = 0; k < got; k++) begin
      checkOutput($sformatf("bp_order%0d", k), seen_y[k], 8'(10 * (k + 1) + 1));
      if (k > 0) checkOutput($sformatf("bp_spacing%0d", k), seen_cyc[k] - last_cyc, 2);
      last_cyc = seen_cyc[k];
    end
    repeat (2) @(negedge clk);

    // Reset while in WAIT with three commands still queued.
    res_ready = 1'b0;
    applyStimulus(4'd1, 8'd200, 8'd100, acc);
    applyStimulus(4'd1, 8'd1, 8'd1, acc);
    applyStimulus(4'd1, 8'd2, 8'd2, acc);
    applyStimulus(4'd1, 8'd3, 8'd3, acc);
    cmd_valid = 1'b0;
    checkOutput("rst_pre_valid", res_valid, 1);
    checkOutput("rst_pre_cf", cf, 1);
    checkOutput("rst_pre_full", cmd_ready, 1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checkOutput("rst_res_valid", res_valid, 0);
    checkOutput("rst_cf", cf, 0);
    checkOutput("rst_cmd_ready", cmd_ready, 1);
    checkOutput("rst_res_y", res_y, 0);
    checkOutput("rst_alu_a", alu_a, 0);
    res_ready = 1'b1;
    saw_valid = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (res_valid) saw_valid = 1'b1;
    end
    checkOutput("rst_no_stale", saw_valid, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_cmd_sequencer.md
Name: alu_cmd_sequencer

Overview:
Sequencing stage wrapped around the combinational ALU. Buffers incoming ALU commands in a small FIFO and issues one at a time to the ALU through registered operand and opcode outputs. Captures the ALU result and flags into a result register with a valid/ready handshake. Keeps an architectural carry flag so that ADC (op 2) chains across commands.

Parameters:
BUS, 8, operand/result width; must match the ALU instance.
DEPTH, 4, command FIFO entries; power of two, at least 2.

Ports:
clk  input  1  single clock, rising edge.
rst_n  input  1  synchronous active-low reset.
cmd_valid  input  1  command offered.
cmd_ready  output  1  command accepted when valid & ready.
cmd_a  input  BUS  operand A.
cmd_b  input  BUS  operand B.
cmd_op  input  4  opcode.
alu_a  output  BUS  registered operand A to the ALU.
alu_b  output  BUS  registered operand B to the ALU.
alu_carry_in  output  1  carry input to the ALU.
alu_op_code  output  4  registered opcode to the ALU.
alu_y  input  BUS  ALU result.
alu_carry_out, alu_borrow, alu_zero, alu_parity, alu_invalid_op  input  1 each  ALU flags.
res_valid  output  1  result available.
res_ready  input  1  consumer takes the result.
res_y  output  BUS  captured result.
res_flags  output  4  {carry, borrow, zero, parity}.
res_err  output  1  invalid opcode.
cf  output  1  architectural carry flag.

Behaviour:
- Reset (rst_n low at a clk edge): FIFO empty, FSM to IDLE. alu_a, alu_b, alu_op_code = 0. res_valid, res_y, res_flags, res_err, cf = 0. cmd_ready is 1 on the first cycle after reset. Reset mid-operation drops all queued and in-flight commands.
- Opcodes: 1 ADD, 2 ADC, 3 SUB, 4 INC, 5 DEC, 6 AND, 7 NOT, 8 ROL, 9 ROR. Any other value is invalid.
- cmd_ready = !fifo_full. There is no bypass: a push into a full FIFO is refused even if a pop happens in the same cycle. A simultaneous push and pop on a non-full FIFO keeps the occupancy unchanged.
- FSM states:
  - IDLE: if the FIFO is non-empty, pop into alu_a/alu_b/alu_op_code and go to EXEC.
  - EXEC: the ALU settles combinationally. At the clock edge, capture alu_y and the flags into the result register, set res_valid, update cf, and go to WAIT.
  - WAIT: on res_ready, the result retires. If the FIFO is non-empty in that same cycle, pop the next command and go to EXEC; otherwise clear res_valid and go to IDLE. Without res_ready, hold every result output stable.
- Latency: a command accepted at edge N loads the operand registers at N+1 (FIFO was empty, FSM in IDLE) and res_valid rises after edge N+2.
- Steady-state throughput: one result per 2 cycles while res_ready stays high.
- alu_carry_in = cf when alu_op_code == 2, else 0.
- cf update at EXEC capture:
  - ops 1 and 2: cf = alu_carry_out.
  - op 3: cf = alu_borrow.
  - all other ops: cf unchanged.
- Invalid opcode: res_err = 1, res_y = 0, res_flags = 0, cf unchanged. The command still produces one result beat.
- FIFO pointers are log2(DEPTH)+1 bits wide; the extra MSB separates full from empty. Pointers wrap naturally.

Optional Feature:
ALU_SEQ_STATS_EN:
- Defined: adds output ports stat_issued[15:0] and stat_errors[15:0]. Both are saturating counters that increment at each EXEC capture; stat_errors counts only when res_err is set. Both clear on reset.
- Undefined: the ports and counters are absent.

Decomposition:
- Package alu_seq_pkg: opcode constants OP_ADD..OP_ROR, OP_MAX = 9, flag bit indices FLG_C = 3, FLG_B = 2, FLG_Z = 1, FLG_P = 0, and the FSM state encoding IDLE/EXEC/WAIT.
- Sub-module alu_cmd_fifo (parameters W, DEPTH; push/pop/full/empty). It holds {op, b, a}.

Test Plan:
- ADD a=55 b=67 with res_ready=1 -> res_y=122, carry=0, zero=0, cf=0; res_valid rises 2 edges after acceptance.
- ADD 200+100, then ADC 1+1 -> first result res_y=44, carry=1, cf=1; second result alu_carry_in=1, res_y=3, cf=0.
- SUB 10-10, then SUB 100-10 -> first result res_y=0, zero=1, borrow=0; second result res_y=90.
- Hold res_ready=0 and offer 7 commands back-to-back -> 5 accepted (1 in the result register, 4 in the FIFO). cmd_ready stays low until res_ready=1. Results then retire in order, one every 2 cycles.
- op 10 with a=3 b=4 and cf=1 beforehand -> res_err=1, res_y=0, res_flags=0, cf stays 1. Under ALU_SEQ_STATS_EN, stat_errors increments by 1.
- Assert rst_n=0 for one edge while in WAIT with 3 commands queued -> next cycle res_valid=0, cf=0, cmd_ready=1, and no stale result appears afterwards.
